// File: rtl/matrix_scroller_if.sv
// Column-word handshake between the pattern generator and the matrix scroller.
// The generator holds colIn/colValid steady until colReady accepts the word.
interface matrix_scroller_if;
    logic [15:0] colIn;
    logic        colValid;
    logic        colReady;

    modport master (output colIn, output colValid, input colReady);
    modport slave  (input colIn, input colValid, output colReady);
endinterface

// File: rtl/matrix_scroller.sv
// Frame source for the 8x8 bicolour matrix scanner: buffers incoming column words
// in a small FIFO and scrolls them into the frame one column per divider tick.
module matrix_scroller #(
    parameter int STEP_DIV   = 125,
    parameter int FIFO_DEPTH = 4,
    parameter int LVL_W      = 3
) (
    input  logic               clk1K,
    input  logic               rstN,
    input  logic               en,
    input  logic               clear,
    input  logic               padBlank,
    matrix_scroller_if.slave   col,
    output logic [127:0]       frame,
    output logic               stepPulse,
    output logic [LVL_W-1:0]   level
);

    localparam int DIV_W = $clog2(STEP_DIV);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t             state;
    state_t             state_nxt;
    logic               tick;
    logic [DIV_W-1:0]   div;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [15:0]        mem [FIFO_DEPTH];
    logic               fifo_empty;
    logic               fifo_full;
    logic               push;
    logic               pop;
    logic               do_step;
    logic [15:0]        new_col;
    logic [127:0]       frame_shifted;

    // Each 16-bit row block holds columns 0..7 from LSB up, so a scroll is a
    // 2-bit left shift per row with the row's pair from the new column entering at the bottom.
    function automatic logic [127:0] shift_in(input logic [127:0] f, input logic [15:0] w);
        logic [127:0] o;
        logic [15:0]  blk;
        o = '0;
        for (int r = 0; r < 8; r++) begin
            blk = f[(7-r)*16 +: 16];
            o[(7-r)*16 +: 16] = {blk[13:0], w[2*r +: 2]};
        end
        return o;
    endfunction

    always_ff @(posedge clk1K or negedge rstN) begin
        if (!rstN) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en)  state_nxt = RUN;
            RUN:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tick = 1'b0;
        if (state == RUN && div == DIV_LAST) tick = 1'b1;
    end

    assign fifo_empty   = (level == '0);
    assign fifo_full    = (level == LVL_FULL);
    assign col.colReady = !fifo_full;
    assign push         = col.colValid && !fifo_full;
    // A word pushed into an empty FIFO on a tick edge is not visible to that step.
    assign pop          = tick && !fifo_empty;
    assign do_step      = tick && (!fifo_empty || padBlank);
    assign new_col      = fifo_empty ? 16'h0000 : mem[rd_ptr];
    assign frame_shifted = shift_in(frame, new_col);

    always_ff @(posedge clk1K or negedge rstN) begin
        if (!rstN)                      div <= '0;
        else if (clear)                 div <= '0;
        else if (state != RUN || tick)  div <= '0;
        else                            div <= div + DIV_W'(1);
    end

    always_ff @(posedge clk1K or negedge rstN) begin
        if (!rstN) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk1K) begin
        if (push && !clear) mem[wr_ptr] <= col.colIn;
    end

    always_ff @(posedge clk1K or negedge rstN) begin
        if (!rstN) begin
            frame     <= '0;
            stepPulse <= 1'b0;
        end else if (clear) begin
            frame     <= '0;
            stepPulse <= 1'b0;
        end else begin
            stepPulse <= do_step;
            if (do_step) frame <= frame_shifted;
        end
    end

endmodule

// File: tb/tb_matrix_scroller.sv
// Self-checking bench for matrix_scroller against a column-list/queue reference model.
module tb_matrix_scroller;
    localparam int SD  = 4;
    localparam int DEP = 4;
    localparam int LW  = 3;

    logic           clk1K = 1'b0;
    logic           rstN;
    logic           en;
    logic           clear;
    logic           padBlank;
    logic [127:0]   frame;
    logic           stepPulse;
    logic [LW-1:0]  level;

    matrix_scroller_if cif ();

    matrix_scroller #(.STEP_DIV(SD), .FIFO_DEPTH(DEP), .LVL_W(LW)) dut (
        .clk1K(clk1K), .rstN(rstN), .en(en), .clear(clear), .padBlank(padBlank),
        .col(cif), .frame(frame), .stepPulse(stepPulse), .level(level)
    );

    always #5 clk1K = ~clk1K;

    int checks = 0;
    int errors = 0;

    // Reference model: pending words, visible columns 0..7, run flag, step phase
    logic [15:0] mq [$];
    logic [15:0] mcols [8];
    bit          mrun;
    int          mdiv;
    bit          mpulse;

    function automatic logic [127:0] exp_frame();
        logic [127:0] f;
        f = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                f[(7-r)*16 + 2*c +: 2] = mcols[c][2*r +: 2];
        return f;
    endfunction

    function automatic logic [15:0] col0_of(input logic [127:0] f);
        logic [15:0] w;
        for (int r = 0; r < 8; r++) w[2*r +: 2] = f[(7-r)*16 +: 2];
        return w;
    endfunction

    task automatic model_reset();
        mq.delete();
        foreach (mcols[c]) mcols[c] = '0;
        mrun = 0; mdiv = 0; mpulse = 0;
    endtask

    task automatic cycle(output bit acc);
        bit          tk;
        logic [15:0] w;
        acc = cif.colValid && (mq.size() != DEP);
        if (clear) begin
            mq.delete();
            foreach (mcols[c]) mcols[c] = '0;
            mdiv = 0; mpulse = 0;
        end else begin
            tk = mrun && (mdiv == SD - 1);
            mpulse = 0;
            if (tk && (mq.size() != 0 || padBlank)) begin
                w = 16'h0000;
                if (mq.size() != 0) w = mq.pop_front();
                for (int c = 7; c > 0; c--) mcols[c] = mcols[c-1];
                mcols[0] = w;
                mpulse = 1;
            end
            if (acc) mq.push_back(cif.colIn);
            mdiv = (!mrun || tk) ? 0 : mdiv + 1;
        end
        mrun = en;
        @(posedge clk1K);
        #1;
    endtask

    task automatic step_wait(input string tag, output int n);
        bit a;
        n = 0;
        do begin
            cycle(a);
            n++;
        end while (!mpulse && n < 8*SD);
        checks++;
        if (!mpulse) begin
            errors++;
            $display("FAIL %s_timeout: no step within %0d cycles", tag, n);
        end
    endtask

    task automatic test_reset();
        bit a;
        int n;
        rstN = 0; en = 0; clear = 0; padBlank = 0;
        cif.colValid = 0; cif.colIn = '0;
        model_reset();
        #12;
        checks++;
        if (frame !== 128'h0 || level !== '0 || cif.colReady !== 1'b1 || stepPulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: frame=%h level=%0d ready=%b pulse=%b, want 0/0/1/0",
                     frame, level, cif.colReady, stepPulse);
        end
        rstN = 1;
        cif.colValid = 1; cif.colIn = 16'($urandom) | 16'h0001;
        en = 1; padBlank = 1;
        cycle(a);
        cif.colValid = 0;
        step_wait("reset_load", n);
        checks++;
        if (frame !== exp_frame()) begin
            errors++;
            $display("FAIL reset_load_frame: got %h want %h", frame, exp_frame());
        end
        #3 rstN = 0;
        #1;
        checks++;
        if (frame !== 128'h0 || level !== '0 || cif.colReady !== 1'b1 || stepPulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: frame=%h level=%0d ready=%b pulse=%b, want 0/0/1/0",
                     frame, level, cif.colReady, stepPulse);
        end
        model_reset();
        en = 0; padBlank = 0;
        #1 rstN = 1;
        cycle(a);
    endtask

    task automatic test_basic_scroll();
        bit a;
        int n;
        cif.colValid = 1; cif.colIn = 16'h0003;
        cycle(a);
        cif.colValid = 0;
        en = 1; padBlank = 1;
        step_wait("basic_first", n);
        checks++;
        if (n != SD + 1 || stepPulse !== 1'b1 || frame[113:112] !== 2'b11) begin
            errors++;
            $display("FAIL basic_first: cycles=%0d pulse=%b px=%b, want %0d/1/11",
                     n, stepPulse, frame[113:112], SD + 1);
        end
        cycle(a);
        checks++;
        if (stepPulse !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse_width: pulse=%b want 0", stepPulse);
        end
        for (int k = 0; k < 7; k++) step_wait("basic_shift", n);
        checks++;
        if (frame !== (128'h3 << 126)) begin
            errors++;
            $display("FAIL basic_col7: got %h want %h", frame, 128'h3 << 126);
        end
        step_wait("basic_out", n);
        checks++;
        if (frame !== 128'h0) begin
            errors++;
            $display("FAIL basic_discard: got %h want 0", frame);
        end
    endtask

    task automatic test_full_fifo();
        bit          a;
        int          n;
        logic [15:0] w [5];
        en = 0; padBlank = 0;
        cycle(a);
        foreach (w[i]) w[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) begin
            cif.colValid = 1; cif.colIn = w[i];
            cycle(a);
        end
        cif.colIn = w[4];
        checks++;
        if (level !== LW'(4) || cif.colReady !== 1'b0) begin
            errors++;
            $display("FAIL full_level: level=%0d ready=%b, want 4/0", level, cif.colReady);
        end
        for (int i = 0; i < 3; i++) cycle(a);
        checks++;
        if (level !== LW'(4) || mq.size() != 4) begin
            errors++;
            $display("FAIL full_hold: level=%0d want 4", level);
        end
        en = 1;
        step_wait("full_pop", n);
        checks++;
        if (level !== LW'(mq.size()) || col0_of(frame) !== w[0]) begin
            errors++;
            $display("FAIL full_pop: level=%0d col0=%h, want %0d/%h", level, col0_of(frame), mq.size(), w[0]);
        end
        n = 0;
        do begin cycle(a); n++; end while (!a && n < 4*SD);
        cif.colValid = 0;
        checks++;
        if (!a || level !== LW'(4) || mq[3] !== w[4]) begin
            errors++;
            $display("FAIL full_fifth: accepted=%b level=%0d, want 1/4", a, level);
        end
        for (int i = 1; i < 5; i++) begin
            step_wait("full_drain", n);
            checks++;
            if (col0_of(frame) !== w[i] || frame !== exp_frame()) begin
                errors++;
                $display("FAIL full_order: col0=%h want %h", col0_of(frame), w[i]);
            end
        end
    endtask

    task automatic test_pad_zero();
        bit           a;
        logic [127:0] ref_f;
        int           bad;
        padBlank = 0; cif.colValid = 0;
        ref_f = exp_frame();
        bad = 0;
        for (int i = 0; i < 10*SD + 2; i++) begin
            cycle(a);
            if (frame !== ref_f || stepPulse !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL pad_zero_hold: %0d cycles differed, frame=%h want %h", bad, frame, ref_f);
        end
        cif.colValid = 1; cif.colIn = 16'($urandom) | 16'h8000;
        cycle(a);
        cif.colValid = 0;
        bad = 0;
        for (int i = 0; i < SD + 1; i++) begin
            cycle(a);
            if (stepPulse !== mpulse || frame !== exp_frame()) bad++;
        end
        checks++;
        if (bad != 0 || level !== LW'(mq.size())) begin
            errors++;
            $display("FAIL pad_zero_phase: %0d cycles differed, level=%0d want %0d", bad, level, mq.size());
        end
    endtask

    task automatic test_simul_push_pop();
        bit          a;
        int          n;
        logic [15:0] w;
        en = 1; padBlank = 1; cif.colValid = 0;
        n = 0;
        while ((mq.size() != 0 || !mrun || mdiv != SD - 1) && n < 8*SD) begin
            cycle(a);
            n++;
        end
        w = 16'($urandom) | 16'h0100;
        cif.colValid = 1; cif.colIn = w;
        cycle(a);
        cif.colValid = 0;
        checks++;
        if (stepPulse !== 1'b1 || level !== LW'(1) || col0_of(frame) !== 16'h0000 || frame !== exp_frame()) begin
            errors++;
            $display("FAIL simul_step: pulse=%b level=%0d col0=%h, want 1/1/0000", stepPulse, level, col0_of(frame));
        end
        step_wait("simul_next", n);
        checks++;
        if (col0_of(frame) !== w || level !== '0) begin
            errors++;
            $display("FAIL simul_next: col0=%h level=%0d, want %h/0", col0_of(frame), level, w);
        end
    endtask

    task automatic test_clear();
        bit a;
        int bad;
        en = 0; padBlank = 0;
        for (int i = 0; i < 3; i++) begin
            cif.colValid = 1; cif.colIn = 16'($urandom);
            cycle(a);
        end
        checks++;
        if (level !== LW'(3)) begin
            errors++;
            $display("FAIL clear_prefill: level=%0d want 3", level);
        end
        cif.colIn = 16'($urandom) | 16'h0001;
        clear = 1;
        cycle(a);
        clear = 0; cif.colValid = 0;
        checks++;
        if (level !== '0 || frame !== 128'h0 || stepPulse !== 1'b0) begin
            errors++;
            $display("FAIL clear_flush: level=%0d frame=%h pulse=%b, want 0/0/0", level, frame, stepPulse);
        end
        en = 1;
        bad = 0;
        for (int i = 0; i < 3*SD; i++) begin
            cycle(a);
            if (stepPulse !== 1'b0 || frame !== 128'h0 || level !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clear_after: %0d cycles with activity, frame=%h level=%0d", bad, frame, level);
        end
    endtask

    task automatic test_random();
        bit a;
        a = 1;
        for (int i = 0; i < 1500; i++) begin
            en       = ($urandom_range(0, 9) != 0);
            padBlank = $urandom_range(0, 1);
            clear    = ($urandom_range(0, 59) == 0);
            if (!cif.colValid || a) begin
                cif.colValid = ($urandom_range(0, 2) != 0);
                cif.colIn    = 16'($urandom);
            end
            cycle(a);
            checks++;
            if (frame !== exp_frame() || level !== LW'(mq.size()) || stepPulse !== mpulse ||
                cif.colReady !== (mq.size() != DEP)) begin
                errors++;
                $display("FAIL random_%0d: frame=%h lvl=%0d pulse=%b rdy=%b, want %h/%0d/%b/%b",
                         i, frame, level, stepPulse, cif.colReady, exp_frame(), mq.size(), mpulse,
                         mq.size() != DEP);
            end
        end
        clear = 0; cif.colValid = 0;
    endtask

    initial begin
        test_reset();
        test_basic_scroll();
        test_full_fifo();
        test_pad_zero();
        test_simul_push_pop();
        test_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
